heart_fall_anim_ctrl: RTL



---
 rtl/heart_fx_pkg.sv | 36 +++
 rtl/heart_frag_x_mover.sv | 56 +++++
 rtl/heart_fall_anim_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/heart_fx_pkg.sv
// heart_fx_pkg
// Shared types and widths for the heart "falls apart" motion controller.
//   state_e        : controller FSM states (idle / falling / done pulse)
//   X_W, Y_W, V_W  : coordinate and velocity widths
//   SUM_W          : width of the signed y + vy sum (wide enough to hold
//                    negative results and values past the 10-bit y range)
//   vy_t           : signed vertical velocity
//   sat_offset_x() : x + offset, saturated at a limit
package heart_fx_pkg;

  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned V_W   = 6;
  localparam int unsigned SUM_W = 12;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFall = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef logic signed [V_W-1:0] vy_t;

  // Adds an unsigned offset to an x coordinate, clamping to lim.
  function automatic logic [X_W-1:0] sat_offset_x(input logic [X_W-1:0] x,
                                                  input int unsigned     off,
                                                  input int unsigned     lim);
    logic [X_W:0] s;
    s = {1'b0, x} + (X_W+1)'(off);
    if (s > (X_W+1)'(lim)) begin
      return X_W'(lim);
    end
    return s[X_W-1:0];
  endfunction

endpackage

// File: rtl/heart_frag_x_mover.sv
// heart_frag_x_mover
// Horizontal position register for one heart fragment. Loads a start x and
// then drifts by DRIFT pixels per step in the direction given by DIR
// (negative: towards 0, saturating at 0; otherwise towards the right edge,
// saturating at SCREEN_W-1).
// Ports:
//   i_clk     clock
//   i_rst_n   asynchronous active-low reset (x returns to 0)
//   i_load    load i_load_x (takes priority over i_step)
//   i_load_x  start x
//   i_step    advance one frame of drift
//   o_x       current x
module heart_frag_x_mover
  import heart_fx_pkg::*;
#(
  parameter int          DIR      = 1,
  parameter int unsigned DRIFT    = 1,
  parameter int unsigned SCREEN_W = 1280
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_load,
  input  logic [X_W-1:0] i_load_x,
  input  logic           i_step,
  output logic [X_W-1:0] o_x
);

  logic [X_W-1:0] r_x;
  logic [X_W-1:0] w_x_stepped;

  if (DIR < 0) begin : g_left
    always_comb begin
      w_x_stepped = (r_x >= X_W'(DRIFT)) ? (r_x - X_W'(DRIFT)) : '0;
    end
  end else begin : g_right
    logic [X_W:0] w_wide;
    always_comb begin
      w_wide      = {1'b0, r_x} + (X_W+1)'(DRIFT);
      w_x_stepped = (w_wide >= (X_W+1)'(SCREEN_W - 1)) ? X_W'(SCREEN_W - 1)
                                                        : w_wide[X_W-1:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x <= '0;
    end else if (i_load) begin
      r_x <= i_load_x;
    end else if (i_step) begin
      r_x <= w_x_stepped;
    end
  end

  assign o_x = r_x;

endmodule

// File: rtl/heart_fall_anim_ctrl.sv
// heart_fall_anim_ctrl
// Per-frame motion controller for the "heart falls apart" effect. A trigger
// latches the heart position; each new_frame_in then moves two fragments:
// shared y under an upward kick plus gravity, x drifting apart. Ends after
// FALL_FRAMES updates or when y reaches the bottom of the screen, with a
// one-cycle done_out pulse.
// Optional build macro HEART_FALL_RETRIGGER_EN: a trigger while falling
// restarts the animation from the new start position (no done pulse).
// Ports:
//   clk_in            clock
//   rst_n_in          asynchronous active-low reset
//   new_frame_in      one-cycle pulse per video frame
//   trigger_in        one-cycle pulse, starts the animation
//   start_x_in/_y_in  heart position sampled on trigger
//   left_x/y_out      left fragment position
//   right_x/y_out     right fragment position
//   left/right_mirror_out  renderer mirror flags (constant 0 / 1)
//   active_out        high while fragments are drawn
//   done_out          one-cycle pulse at animation end
module heart_fall_anim_ctrl
  import heart_fx_pkg::*;
#(
  parameter int unsigned SCREEN_W    = 1280,
  parameter int unsigned SCREEN_H    = 720,
  parameter int unsigned HALF_OFFSET = 4,
  parameter int unsigned INIT_VY     = 3,
  parameter int unsigned GRAVITY     = 1,
  parameter int unsigned V_MAX       = 8,
  parameter int unsigned DRIFT       = 1,
  parameter int unsigned FALL_FRAMES = 60
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  input  logic           new_frame_in,
  input  logic           trigger_in,
  input  logic [X_W-1:0] start_x_in,
  input  logic [Y_W-1:0] start_y_in,
  output logic [X_W-1:0] left_x_out,
  output logic [Y_W-1:0] left_y_out,
  output logic [X_W-1:0] right_x_out,
  output logic [Y_W-1:0] right_y_out,
  output logic           left_mirror_out,
  output logic           right_mirror_out,
  output logic           active_out,
  output logic           done_out
);

  localparam int unsigned CNT_W = $clog2(FALL_FRAMES + 1);
  localparam logic signed [SUM_W-1:0] Y_LIMIT = SUM_W'(SCREEN_H);
  localparam logic signed [SUM_W-1:0] Y_MAX   = SUM_W'((2 ** Y_W) - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [Y_W-1:0]   r_y;
  vy_t              r_vy;
  logic [CNT_W-1:0] r_cnt;

  logic             w_restart;
  logic             w_load;
  logic             w_step;
  logic             w_term;
  logic signed [SUM_W-1:0] w_y_sum;
  logic [Y_W-1:0]   w_y_next;
  logic signed [V_W:0] w_vy_inc;
  vy_t              w_vy_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [X_W-1:0]   w_right_start;

`ifdef HEART_FALL_RETRIGGER_EN
  assign w_restart = (r_state == StFall) && trigger_in;
`else
  assign w_restart = 1'b0;
`endif

  assign w_load = ((r_state == StIdle) && trigger_in) || w_restart;
  // A reload owns the cycle; a coincident frame pulse is not counted.
  assign w_step = (r_state == StFall) && new_frame_in && !w_restart;

  // Vertical step: signed sum so upward motion can go below 0 before clamping.
  always_comb begin
    w_y_sum = $signed({{(SUM_W - Y_W){1'b0}}, r_y})
            + $signed({{(SUM_W - V_W){r_vy[V_W-1]}}, r_vy});
    if (w_y_sum < 0) begin
      w_y_next = '0;
    end else if (w_y_sum > Y_MAX) begin
      w_y_next = '1;
    end else begin
      w_y_next = w_y_sum[Y_W-1:0];
    end
  end

  always_comb begin
    w_vy_inc = $signed({r_vy[V_W-1], r_vy}) + $signed((V_W+1)'(GRAVITY));
    if (w_vy_inc > $signed((V_W+1)'(V_MAX))) begin
      w_vy_next = vy_t'(V_MAX);
    end else begin
      w_vy_next = w_vy_inc[V_W-1:0];
    end
  end

  assign w_cnt_next    = r_cnt + CNT_W'(1);
  assign w_term        = w_step && ((w_y_sum >= Y_LIMIT) || (w_cnt_next == CNT_W'(FALL_FRAMES)));
  assign w_right_start = sat_offset_x(start_x_in, HALF_OFFSET, SCREEN_W - 1);

  // FSM state register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: if (trigger_in) w_state_next = StFall;
      StFall: begin
        if (w_restart) begin
          w_state_next = StFall;
        end else if (w_term) begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    active_out = 1'b0;
    done_out   = 1'b0;
    unique case (r_state)
      StFall:  active_out = 1'b1;
      StDone:  done_out   = 1'b1;
      default: ;
    endcase
  end

  // Vertical state shared by both fragments; positions hold after the end.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_y   <= '0;
      r_vy  <= '0;
      r_cnt <= '0;
    end else if (w_load) begin
      r_y   <= start_y_in;
      r_vy  <= vy_t'(0) - vy_t'(INIT_VY);
      r_cnt <= '0;
    end else if (w_step) begin
      r_y   <= w_y_next;
      r_vy  <= w_vy_next;
      r_cnt <= w_cnt_next;
    end
  end

  heart_frag_x_mover #(
    .DIR      (-1),
    .DRIFT    (DRIFT),
    .SCREEN_W (SCREEN_W)
  ) u_left_x (
    .i_clk    (clk_in),
    .i_rst_n  (rst_n_in),
    .i_load   (w_load),
    .i_load_x (start_x_in),
    .i_step   (w_step),
    .o_x      (left_x_out)
  );

  heart_frag_x_mover #(
    .DIR      (1),
    .DRIFT    (DRIFT),
    .SCREEN_W (SCREEN_W)
  ) u_right_x (
    .i_clk    (clk_in),
    .i_rst_n  (rst_n_in),
    .i_load   (w_load),
    .i_load_x (w_right_start),
    .i_step   (w_step),
    .o_x      (right_x_out)
  );

  assign left_y_out       = r_y;
  assign right_y_out      = r_y;
  assign left_mirror_out  = 1'b0;
  assign right_mirror_out = 1'b1;

endmodule
